prog_counter: RTL
=================

PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits, legal 2..32.
REQ-002 Parameter PRESCALE, default 1: clk cycles per count step, legal 1..65535.
REQ-003 clk  input  1  clock; all state SHALL change on its rising edge except on reset.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 clr  input  1  synchronous clear of count, state and prescaler.
REQ-006 en  input  1  count enable; when low, count and prescaler SHALL hold.
REQ-007 load  input  1  synchronous load of load_val.
REQ-008 load_val  input  WIDTH  value to load.
REQ-009 modulus  input  WIDTH  terminal count; count range SHALL be 0..modulus.
REQ-010 one_shot  input  1  1 = stop at terminal, 0 = wrap.
REQ-011 dir  input  1  1 = down, 0 = up; present only with PROG_COUNTER_UPDOWN_EN.
REQ-012 q  output  WIDTH  current count, registered.
REQ-013 tick  output  1  one-cycle pulse on the terminal step, registered.
REQ-014 done  output  1  high while halted in one-shot DONE state.

Function
REQ-015 Priority SHALL be rst > clr > load > step.
REQ-016 A step SHALL occur in a cycle where en=1, the state is RUN and the prescaler strobe is high.
REQ-017 The prescaler strobe SHALL be high for one cycle in every PRESCALE enabled cycles; with PRESCALE=1 it SHALL be high every enabled cycle.
REQ-018 The FSM SHALL have states RUN and DONE; reset and clr SHALL enter RUN.
REQ-019 Up-count terminal condition SHALL be q >= modulus; down-count terminal condition SHALL be q == 0.
REQ-020 On a non-terminal step, q SHALL become q+1 (up) or q-1 (down), with no WIDTH overflow possible.
REQ-021 On a terminal step with one_shot=0, q SHALL wrap to 0 (up) or to modulus (down); tick SHALL be 1 in the following cycle, coincident with the wrapped q.
REQ-022 On a terminal step with one_shot=1, q SHALL hold, tick SHALL pulse once, and the FSM SHALL move to DONE with done=1 from the next cycle.
REQ-023 In DONE, steps SHALL be ignored; clr or load SHALL return the FSM to RUN.
REQ-024 load SHALL set q to min(load_val, modulus), reset the prescaler phase, and produce no tick.
REQ-025 If modulus changes to a value below q during an up-count, the next step SHALL be terminal.
REQ-026 With modulus=0, q SHALL stay 0 and every step SHALL be terminal.
REQ-027 A change of one_shot or dir SHALL take effect on the next step; a mid-count change of dir SHALL NOT alter q.
REQ-028 tick SHALL never be high for two consecutive cycles unless PRESCALE=1 and every step is terminal.

Reset
REQ-029 On rst: q=0, tick=0, done=0, FSM=RUN, prescaler phase=0, held until rst deasserts.
REQ-030 rst asserted mid-operation SHALL discard any pending tick.

Configuration
REQ-031 With PROG_COUNTER_UPDOWN_EN defined, the dir port and down-count logic SHALL exist.
REQ-032 Without PROG_COUNTER_UPDOWN_EN, dir SHALL be absent and the block SHALL count up only.

Structure
REQ-033 FSM state enumeration and the PRESCALE width constant SHALL be in package prog_counter_pkg.
REQ-034 The prescaler SHALL be the sub-module prog_counter_prescaler (inputs clk, rst, clr_phase, en; output strobe).

Verification
REQ-035 WIDTH=4, PRESCALE=1, modulus=9, en=1, one_shot=0 -> q sequence 0..9,0; tick high only with q=0 after 9, once every 10 cycles.
REQ-036 PRESCALE=3, modulus=2 -> q advances every 3rd cycle; tick period is 9 cycles; en low for 5 cycles freezes q and the prescaler phase.
REQ-037 one_shot=1, modulus=5 -> q stops at 5, single tick, done=1; load with load_val=2 -> done=0, q=2, counting resumes.
REQ-038 load_val=12 with modulus=7 -> q=7, no tick; next step -> q=0 with tick.
REQ-039 PROG_COUNTER_UPDOWN_EN, dir=1, modulus=3 -> sequence 3,2,1,0,3 with tick on the wrap to 3; dir flipped at q=2 -> next q=3.
REQ-040 rst asserted asynchronously mid-count at q=6 -> q=0, tick=0, done=0 immediately; clr and load asserted together -> q=0 (clr wins).

Source files
------------

// File: rtl/prog_counter_pkg.sv
// Shared types and constants for the programmable counter block.
package prog_counter_pkg;

   typedef enum logic {RUN = 1'b0, DONE = 1'b1} state_t;

   // Prescaler phase width; covers PRESCALE values up to 65535.
   localparam int PS_W = 16;

endpackage

// File: rtl/prog_counter_prescaler.sv
// Enable-gated prescaler: strobe is high on one of every PRESCALE enabled cycles.
module prog_counter_prescaler
   import prog_counter_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_phase,
   input  logic en,
   output logic strobe
);

   localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

   logic [PS_W-1:0] phase;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase <= '0;
      end else if (clr_phase) begin
         phase <= '0;
      end else if (en) begin
         phase <= (phase == LAST) ? '0 : phase + 1'b1;
      end
   end

   // The phase freezes with en low, so the strobe only fires on enabled cycles.
   assign strobe = en && (phase == LAST);

endmodule

// File: rtl/prog_counter.sv
// Programmable modulus counter with prescaler, one-shot/wrap modes and a terminal tick.
// Define PROG_COUNTER_UPDOWN_EN to add the dir port and down counting.
module prog_counter
   import prog_counter_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] modulus,
   input  logic             one_shot,
`ifdef PROG_COUNTER_UPDOWN_EN
   input  logic             dir,
`endif
   output logic [WIDTH-1:0] q,
   output logic             tick,
   output logic             done
);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic             tick_nxt;
   logic             strobe;
   logic             step;
   logic             terminal;
   logic             down;

`ifdef PROG_COUNTER_UPDOWN_EN
   assign down = dir;
`else
   assign down = 1'b0;
`endif

   function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v,
                                              input logic [WIDTH-1:0] m);
      return (v > m) ? m : v;
   endfunction

   prog_counter_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk       (clk),
      .rst       (rst),
      .clr_phase (clr | load),
      .en        (en),
      .strobe    (strobe)
   );

   assign step = strobe && (state == RUN);

   // ">=" so a modulus lowered below q still terminates on the next step.
   assign terminal = down ? (q == '0) : (q >= modulus);

   always_comb begin
      state_nxt = state;
      q_nxt     = q;
      tick_nxt  = 1'b0;
      if (clr) begin
         state_nxt = RUN;
         q_nxt     = '0;
      end else if (load) begin
         state_nxt = RUN;
         q_nxt     = clamp(load_val, modulus);
      end else if (step) begin
         if (terminal) begin
            tick_nxt = 1'b1;
            if (one_shot) begin
               state_nxt = DONE;
            end else begin
               q_nxt = down ? modulus : '0;
            end
         end else begin
            q_nxt = down ? q - 1'b1 : q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         q     <= '0;
         tick  <= 1'b0;
      end else begin
         state <= state_nxt;
         q     <= q_nxt;
         tick  <= tick_nxt;
      end
   end

   assign done = (state == DONE);

endmodule
